pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Parametrised program-counter unit for the pipelined RV32IC/IM core, replacing the plain 32-bit PC register in the IF stage.
- Computes the next fetch address from these sources: sequential +2/+4 increment (compressed-aware), branch/jump redirect from EX, trap entry, mret return, and debug halt/resume.
- Holds the saved exception PC and the last faulting address, and produces fetch-valid qualification for the IF/ID register.

Parameters:
XLEN, 32, PC and address width in bits
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
TRAP_VECTOR, 32'h0000_0100, PC loaded on trap entry or misaligned redirect
C_EXT, 1, 1 = 16-bit alignment and +2 increment allowed; 0 = 32-bit alignment only, +4 always

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
stall  input  1  hold PC (hazard unit); fetch_valid deasserted
is_compressed  input  1  instruction at pc is 16-bit (ignored when C_EXT=0)
redirect_valid  input  1  taken branch/jump from EX, single-cycle pulse
redirect_target  input  XLEN  redirect address
trap_valid  input  1  exception/interrupt accepted this cycle
trap_epc  input  XLEN  PC to save on trap
mret_valid  input  1  return from trap
halt_req  input  1  debug/ebreak halt request
resume  input  1  leave HALT state
pc  output  XLEN  current fetch address (registered)
pc_next  output  XLEN  combinational next-PC value
fetch_valid  output  1  pc is a valid fetch this cycle
epc  output  XLEN  saved exception PC (registered)
badaddr  output  XLEN  last misaligned redirect target (registered)
misalign_err  output  1  registered one-cycle pulse on misaligned redirect
halted  output  1  FSM in HALT

Behaviour:
- Reset (rst=1 at edge): pc=RESET_VECTOR, epc=0, badaddr=0, misalign_err=0, state=RUN. rst overrides every other input. Reset mid-halt or mid-stall returns to RUN.
- FSM states:
  - RUN: halted=0, fetch_valid = ~stall.
  - HALT: halted=1, fetch_valid=0, pc is held.
- next-PC priority, highest first:
  1. rst
  2. trap_valid: pc_next=TRAP_VECTOR, epc<=trap_epc
  3. mret_valid: pc_next=epc
  4. redirect_valid: if misaligned, pc_next=TRAP_VECTOR, badaddr<=redirect_target, misalign_err pulses the next cycle, epc<=redirect_target; else pc_next=redirect_target
  5. HALT state, or halt_req in RUN: pc_next=pc, and HALT is entered on the same edge
  6. stall: pc_next=pc
  7. sequential: pc + 2 if (C_EXT && is_compressed), else pc + 4
- Misaligned definition: target[0]=1 when C_EXT=1; target[1:0]!=0 when C_EXT=0.
- trap_valid, mret_valid and redirect_valid are honoured even in HALT and even under stall, because flushes must not be lost.
- A trap, mret or redirect while in HALT updates pc but stays in HALT.
- HALT -> RUN on resume=1 with halt_req=0. If resume and halt_req are both high, stay in HALT.
- Latency: the selected pc_next appears on pc one cycle later. There is no bubble insertion; flushing of IF/ID is the caller's job.
- Arithmetic is modulo 2^XLEN: pc=32'hFFFF_FFFC +4 wraps to 0, with no error.
- mret with epc misaligned: jump anyway (epc is always written aligned except via a misaligned trap path).
- misalign_err is high for exactly one cycle and is not sticky.

Test Plan:
- Reset then 3 free-running cycles, no C: pc = 0x0, 0x4, 0x8, 0xC; fetch_valid=1 throughout.
- C_EXT=1, pc=0x10, is_compressed=1 for one cycle then 0: pc = 0x12, then 0x16. Stall asserted 2 cycles: pc holds at 0x16, fetch_valid=0.
- redirect_valid with target 0x200 while stall=1: pc=0x200 next cycle. Target 0x203: pc=TRAP_VECTOR (0x100), badaddr=0x203, misalign_err=1 for one cycle.
- trap_valid with trap_epc=0x44 and redirect_valid simultaneously: pc=0x100, epc=0x44. mret_valid later: pc=0x44.
- halt_req at pc=0x20: halted=1, pc frozen at 0x20 for 5 cycles. resume: pc=0x24 the cycle after leaving HALT. rst asserted during HALT: pc=RESET_VECTOR, halted=0.
- pc forced to 0xFFFF_FFFC via redirect, one sequential step: pc=0x0000_0000, misalign_err=0.

Source files
------------

// File: rtl/pc_unit.sv
// Program-counter unit for the IF stage: selects the next fetch address from
// reset, trap, mret, EX redirect, debug halt, stall and sequential increment.
module pc_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter bit              C_EXT        = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            is_compressed,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_epc,
    input  logic            mret_valid,
    input  logic            halt_req,
    input  logic            resume,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_next,
    output logic            fetch_valid,
    output logic [XLEN-1:0] epc,
    output logic [XLEN-1:0] badaddr,
    output logic            misalign_err,
    output logic            halted
);

    // Handshake: fetch_valid qualifies pc for the IF/ID register in the same
    // cycle; there is no ready back-pressure other than stall.
    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    logic [0:0]      state;
    logic            misaligned;
    logic            redirect_bad;
    logic [XLEN-1:0] pc_inc;

    assign misaligned   = C_EXT ? redirect_target[0] : (redirect_target[1:0] != 2'b00);
    // A misaligned redirect only matters when neither trap nor mret outranks it.
    assign redirect_bad = !trap_valid && !mret_valid && redirect_valid && misaligned;
    assign pc_inc       = (C_EXT && is_compressed) ? XLEN'(2) : XLEN'(4);

    always_comb begin
        pc_next = pc + pc_inc;
        if (rst)
            pc_next = RESET_VECTOR;
        else if (trap_valid)
            pc_next = TRAP_VECTOR;
        else if (mret_valid)
            pc_next = epc;
        else if (redirect_valid)
            pc_next = misaligned ? TRAP_VECTOR : redirect_target;
        else if (state == ST_HALT || halt_req || stall)
            pc_next = pc;
    end

    assign fetch_valid = (state == ST_RUN) && !stall;
    assign halted      = (state == ST_HALT);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc           <= RESET_VECTOR;
            epc          <= '0;
            badaddr      <= '0;
            misalign_err <= 1'b0;
            state        <= ST_RUN;
        end else begin
            pc           <= pc_next;
            misalign_err <= redirect_bad;
            if (trap_valid)
                epc <= trap_epc;
            else if (redirect_bad)
                epc <= redirect_target;
            if (redirect_bad)
                badaddr <= redirect_target;
            // Halt entry is never dropped, even when a flush wins the pc mux.
            case (state)
                ST_RUN:  if (halt_req) state <= ST_HALT;
                ST_HALT: if (resume && !halt_req) state <= ST_RUN;
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios then random stimulus, both C_EXT
// variants driven in lockstep and compared against an arithmetic model.
module tb_pc_unit;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] TV = 32'h0000_0100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b0, stall = 1'b0, is_compressed = 1'b0;
    logic        redirect_valid = 1'b0, trap_valid = 1'b0, mret_valid = 1'b0;
    logic        halt_req = 1'b0, resume = 1'b0;
    logic [31:0] redirect_target = '0, trap_epc = '0;

    logic [31:0] pc_o[2], pc_next_o[2], epc_o[2], badaddr_o[2];
    logic        fetch_valid_o[2], misalign_err_o[2], halted_o[2];

    pc_unit #(.C_EXT(1'b1)) u_dut_c (
        .clk(clk), .rst(rst), .stall(stall), .is_compressed(is_compressed),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .trap_valid(trap_valid), .trap_epc(trap_epc), .mret_valid(mret_valid),
        .halt_req(halt_req), .resume(resume),
        .pc(pc_o[0]), .pc_next(pc_next_o[0]), .fetch_valid(fetch_valid_o[0]),
        .epc(epc_o[0]), .badaddr(badaddr_o[0]), .misalign_err(misalign_err_o[0]),
        .halted(halted_o[0])
    );

    pc_unit #(.C_EXT(1'b0)) u_dut_nc (
        .clk(clk), .rst(rst), .stall(stall), .is_compressed(is_compressed),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .trap_valid(trap_valid), .trap_epc(trap_epc), .mret_valid(mret_valid),
        .halt_req(halt_req), .resume(resume),
        .pc(pc_o[1]), .pc_next(pc_next_o[1]), .fetch_valid(fetch_valid_o[1]),
        .epc(epc_o[1]), .badaddr(badaddr_o[1]), .misalign_err(misalign_err_o[1]),
        .halted(halted_o[1])
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference model, index 0 = C_EXT=1, index 1 = C_EXT=0.
    logic [31:0] m_pc[2], m_epc[2], m_bad[2];
    logic        m_err[2], m_halt[2];

    function automatic logic [31:0] model_next(input int k);
        logic c = (k == 0);
        logic mis = c ? redirect_target[0] : (redirect_target % 4 != 0);
        if (rst) return RV;
        if (trap_valid) return TV;
        if (mret_valid) return m_epc[k];
        if (redirect_valid) return mis ? TV : redirect_target;
        if (m_halt[k] || halt_req || stall) return m_pc[k];
        return m_pc[k] + ((c && is_compressed) ? 32'd2 : 32'd4);
    endfunction

    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            logic c = (k == 0);
            logic mis = c ? redirect_target[0] : (redirect_target % 4 != 0);
            logic bad_redirect = !trap_valid && !mret_valid && redirect_valid && mis;
            logic [31:0] nxt = model_next(k);
            if (rst) begin
                m_pc[k] = RV; m_epc[k] = 0; m_bad[k] = 0; m_err[k] = 0; m_halt[k] = 0;
            end else begin
                m_pc[k]  = nxt;
                m_err[k] = bad_redirect;
                if (trap_valid) m_epc[k] = trap_epc;
                else if (bad_redirect) m_epc[k] = redirect_target;
                if (bad_redirect) m_bad[k] = redirect_target;
                if (!m_halt[k]) m_halt[k] = halt_req;
                else if (resume && !halt_req) m_halt[k] = 1'b0;
            end
        end
    endtask

    task automatic clear_inputs();
        rst = 0; stall = 0; is_compressed = 0; redirect_valid = 0; trap_valid = 0;
        mret_valid = 0; halt_req = 0; resume = 0; redirect_target = '0; trap_epc = '0;
    endtask

    // Inputs are set by the caller just after a negedge; this checks the
    // combinational outputs, clocks once, then checks the registered outputs.
    task automatic step();
        #1;
        for (int k = 0; k < 2; k++) begin
            check_val($sformatf("pc_next%0d", k), pc_next_o[k], model_next(k));
            if (!rst)
                check_val($sformatf("fetch_valid%0d", k), 32'(fetch_valid_o[k]),
                          32'((!m_halt[k]) && !stall));
        end
        @(posedge clk);
        model_update();
        #1;
        for (int k = 0; k < 2; k++) begin
            check_val($sformatf("pc%0d", k), pc_o[k], m_pc[k]);
            check_val($sformatf("epc%0d", k), epc_o[k], m_epc[k]);
            check_val($sformatf("badaddr%0d", k), badaddr_o[k], m_bad[k]);
            check_val($sformatf("misalign_err%0d", k), 32'(misalign_err_o[k]), 32'(m_err[k]));
            check_val($sformatf("halted%0d", k), 32'(halted_o[k]), 32'(m_halt[k]));
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic redirect_to(input logic [31:0] t);
        redirect_valid = 1; redirect_target = t; step();
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_pc[k] = 'x; m_epc[k] = 'x; m_bad[k] = 'x; m_err[k] = 'x; m_halt[k] = 0;
        end
        @(negedge clk);
        rst = 1; step();
        check_val("reset_pc", pc_o[0], 32'h0);
        check_val("reset_halted", 32'(halted_o[0]), 32'h0);

        step(); check_val("seq_4", pc_o[1], 32'h4);
        step(); check_val("seq_8", pc_o[1], 32'h8);
        step(); check_val("seq_c", pc_o[1], 32'hC);

        redirect_to(32'h10);
        is_compressed = 1; step(); check_val("comp_12", pc_o[0], 32'h12);
        step(); check_val("seq_16", pc_o[0], 32'h16);
        stall = 1; step();
        stall = 1; step(); check_val("stall_hold", pc_o[0], 32'h16);

        stall = 1; redirect_to(32'h200); check_val("redir_stall", pc_o[0], 32'h200);
        redirect_to(32'h203);
        check_val("mis_pc", pc_o[0], TV);
        check_val("mis_bad", badaddr_o[0], 32'h203);
        check_val("mis_err", 32'(misalign_err_o[0]), 32'h1);
        step(); check_val("mis_err_clear", 32'(misalign_err_o[0]), 32'h0);
        redirect_to(32'h202); check_val("nc_mis_pc", pc_o[1], TV);

        trap_valid = 1; trap_epc = 32'h44; redirect_to(32'h300);
        check_val("trap_pc", pc_o[0], TV);
        check_val("trap_epc", epc_o[0], 32'h44);
        step();
        mret_valid = 1; step(); check_val("mret_pc", pc_o[0], 32'h44);

        redirect_to(32'h20);
        halt_req = 1; step(); check_val("halt_enter", 32'(halted_o[0]), 32'h1);
        for (int i = 0; i < 5; i++) step();
        check_val("halt_hold", pc_o[0], 32'h20);
        resume = 1; halt_req = 1; step();
        resume = 1; step(); check_val("resume_pc", pc_o[0], 32'h20);
        step(); check_val("after_resume", pc_o[0], 32'h24);
        halt_req = 1; step();
        rst = 1; halt_req = 1; step();
        check_val("rst_in_halt_pc", pc_o[0], RV);
        check_val("rst_in_halt", 32'(halted_o[0]), 32'h0);

        redirect_to(32'hFFFF_FFFC);
        step();
        check_val("wrap_pc", pc_o[1], 32'h0);
        check_val("wrap_err", 32'(misalign_err_o[1]), 32'h0);

        for (int i = 0; i < 600; i++) begin
            rst            = ($urandom_range(0, 59) == 0);
            stall          = ($urandom_range(0, 3) == 0);
            is_compressed  = $urandom_range(0, 1);
            trap_valid     = ($urandom_range(0, 11) == 0);
            trap_epc       = $urandom & 32'hFFFF_FFFE;
            mret_valid     = ($urandom_range(0, 11) == 0);
            redirect_valid = ($urandom_range(0, 5) == 0);
            redirect_target = $urandom;
            if ($urandom_range(0, 1) == 1) redirect_target[1:0] = 2'b00;
            halt_req       = ($urandom_range(0, 19) == 0);
            resume         = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
